dump_cntrl: RTL and testbench

//  Reader side of the capture RAM. After a capture completes, it reads ENTRIES samples

---
 rtl/dump_cntrl.sv | 133 +++++++++++++
 tb/tb_dump_cntrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_cntrl.sv
// dump_cntrl: streams ENTRIES capture-RAM samples, oldest first, to the UART.
// Define DUMP_CHKSUM_EN to append a two's-complement checksum byte.
module dump_cntrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dump_en,
    input  logic            capture_done,
    input  logic [LOG2-1:0] wr_ptr,
    input  logic [7:0]      rdata,
    input  logic            tx_done,
    output logic            re,
    output logic [LOG2-1:0] raddr,
    output logic [7:0]      tx_data,
    output logic            trmt,
    output logic            busy,
    output logic            dump_done
);

`ifdef DUMP_CHKSUM_EN
    typedef enum logic [2:0] {
        IDLE, READ, LOAD, XMIT, WAIT_TX, CKSUM, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, READ, LOAD, XMIT, WAIT_TX, DONE
    } state_t;
`endif

    localparam logic [LOG2:0]   LP_N    = (LOG2+1)'(ENTRIES);
    localparam logic [LOG2-1:0] LP_LAST = LOG2'(ENTRIES-1);

    state_t          r_state;
    logic [LOG2:0]   r_cnt;
    logic [LOG2-1:0] r_raddr;
    logic [7:0]      r_tx_data;
    logic            r_re;
    logic            r_trmt;
    logic            r_busy;
    logic            r_done;
`ifdef DUMP_CHKSUM_EN
    logic [7:0]      r_chk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_raddr   <= '0;
            r_tx_data <= '0;
            r_re      <= 1'b0;
            r_trmt    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DUMP_CHKSUM_EN
            r_chk     <= '0;
`endif
        end else begin
            r_re   <= 1'b0;
            r_trmt <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dump_en && capture_done) begin
                        // an out-of-range write pointer restarts at the bottom
                        r_raddr <= ({1'b0, wr_ptr} >= LP_N) ? '0 : wr_ptr;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_re    <= 1'b1;
                        r_state <= READ;
`ifdef DUMP_CHKSUM_EN
                        r_chk   <= '0;
`endif
                    end
                end
                READ: r_state <= LOAD;
                LOAD: begin
                    r_tx_data <= rdata;
                    r_trmt    <= 1'b1;
                    r_state   <= XMIT;
`ifdef DUMP_CHKSUM_EN
                    r_chk     <= r_chk + rdata;
`endif
                end
                XMIT: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_raddr <= (r_raddr == LP_LAST) ? '0 : r_raddr + 1'b1;
                    r_state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (r_cnt == LP_N) begin
`ifdef DUMP_CHKSUM_EN
                            r_tx_data <= ~r_chk + 8'd1;
                            r_trmt    <= 1'b1;
                            r_state   <= CKSUM;
`else
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
`endif
                        end else begin
                            r_re    <= 1'b1;
                            r_state <= READ;
                        end
                    end
                end
`ifdef DUMP_CHKSUM_EN
                CKSUM: begin
                    // first cycle carries the strobe; completion only after it
                    if (tx_done && !r_trmt) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
`endif
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign re        = r_re;
    assign raddr     = r_raddr;
    assign tx_data   = r_tx_data;
    assign trmt      = r_trmt;
    assign busy      = r_busy;
    assign dump_done = r_done;

endmodule

// File: tb/tb_dump_cntrl.sv
// tb_dump_cntrl: randomized dumps against a queue-based reference of the
// expected oldest-first byte stream, address order and pulse counts.
module tb_dump_cntrl;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
`ifdef DUMP_CHKSUM_EN
    localparam int NBYTES = ENTRIES + 1;
`else
    localparam int NBYTES = ENTRIES;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dump_en = 1'b0;
    logic            capture_done = 1'b0;
    logic [LOG2-1:0] wr_ptr = '0;
    logic [7:0]      rdata;
    logic            uart_done;
    logic            glitch = 1'b0;
    logic            tx_done;
    logic            re, trmt, busy, dump_done;
    logic [LOG2-1:0] raddr;
    logic [7:0]      tx_data;

    logic [7:0] mem [0:511];
    logic [7:0] txq [$];
    int         raddrq [$];
    int         done_cnt = 0;
    int         badaddr = 0;
    int         unstable = 0;
    int         checks = 0;
    int         failures = 0;
    int         tx0, ra0, dn0, bad0, uns0;

    assign tx_done = uart_done | glitch;

    dump_cntrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .dump_en(dump_en),
        .capture_done(capture_done), .wr_ptr(wr_ptr),
        .rdata(rdata), .tx_done(tx_done), .re(re), .raddr(raddr),
        .tx_data(tx_data), .trmt(trmt), .busy(busy),
        .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (re) rdata <= mem[raddr];

    always @(negedge clk) begin
        if (re) begin
            raddrq.push_back(int'(raddr));
            if (int'(raddr) >= ENTRIES) badaddr++;
        end
        if (dump_done) done_cnt++;
    end

    initial begin
        logic [7:0] b;
        int d;
        uart_done = 1'b0;
        forever begin
            @(negedge clk);
            uart_done = 1'b0;
            if (rst_n && trmt) begin
                b = tx_data;
                txq.push_back(b);
                d = $urandom_range(1, 5);
                repeat (d) begin
                    @(negedge clk);
                    if (tx_data !== b) unstable++;
                end
                uart_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_dump(input int wp);
        tx0  = txq.size();
        ra0  = raddrq.size();
        dn0  = done_cnt;
        bad0 = badaddr;
        uns0 = unstable;
        wr_ptr = wp[LOG2-1:0];
        capture_done = 1'b1;
        dump_en = 1'b1;
        @(negedge clk);
        dump_en = 1'b0;
        wr_ptr = LOG2'($urandom_range(0, 511));
    endtask

    task automatic wait_done(input string tag, input bit noise);
        bit seen = 0;
        bit gl = 0;
        for (int c = 0; c < 12000 && !seen; c++) begin
            @(negedge clk);
            dump_en = 1'b0;
            glitch = 1'b0;
            if (dump_done) seen = 1;
            else if (noise) begin
                if (c == 40) begin dump_en = 1'b1; capture_done = 1'b0; end
                if (c == 100) capture_done = 1'b1;
                if (c == 200) dump_en = 1'b1;
                if (c > 60 && re && !gl) begin glitch = 1'b1; gl = 1; end
            end
        end
        chk({tag, ".done_seen"}, seen, 1);
        @(negedge clk);
        glitch = 1'b0;
        dump_en = 1'b0;
    endtask

    task automatic check_dump(input string tag, input int wp);
        int wpe, mis_b, mis_a, sum, nre, e;
        wpe = (wp >= ENTRIES) ? 0 : wp;
        mis_b = 0;
        mis_a = 0;
        sum = 0;
        nre = raddrq.size() - ra0;
        chk({tag, ".nbytes"}, txq.size() - tx0, NBYTES);
        chk({tag, ".nre"}, nre, ENTRIES);
        for (int k = 0; k < ENTRIES; k++) begin
            e = int'(mem[(wpe + k) % ENTRIES]);
            sum += e;
            if (tx0 + k >= txq.size()) mis_b++;
            else if (int'(txq[tx0 + k]) != e) mis_b++;
            if (ra0 + k >= raddrq.size()) mis_a++;
            else if (raddrq[ra0 + k] != (wpe + k) % ENTRIES) mis_a++;
        end
        chk({tag, ".byte_mismatches"}, mis_b, 0);
        chk({tag, ".addr_mismatches"}, mis_a, 0);
        if (nre >= ENTRIES) begin
            chk({tag, ".first_raddr"}, raddrq[ra0], wpe);
            chk({tag, ".second_raddr"}, raddrq[ra0 + 1], (wpe + 1) % ENTRIES);
            chk({tag, ".last_raddr"}, raddrq[ra0 + ENTRIES - 1],
                (wpe + ENTRIES - 1) % ENTRIES);
        end
`ifdef DUMP_CHKSUM_EN
        if (txq.size() > tx0 + ENTRIES)
            chk({tag, ".cksum"}, txq[tx0 + ENTRIES], (256 - sum % 256) % 256);
`endif
        chk({tag, ".raddr_end"}, raddr, wpe);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".done_pulses"}, done_cnt - dn0, 1);
        chk({tag, ".bad_addr"}, badaddr - bad0, 0);
        chk({tag, ".tx_unstable"}, unstable - uns0, 0);
    endtask

    initial begin
        int wp;
        bit act;
        bit got;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);

        repeat (3) @(negedge clk);
        chk("reset.re", re, 0);
        chk("reset.trmt", trmt, 0);
        chk("reset.busy", busy, 0);
        chk("reset.dump_done", dump_done, 0);
        chk("reset.raddr", raddr, 0);
        chk("reset.tx_data", tx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_dump(0);
        wait_done("inorder", 0);
        check_dump("inorder", 0);

        start_dump(383);
        wait_done("wrap383", 0);
        check_dump("wrap383", 383);

        capture_done = 1'b0;
        wr_ptr = 9'd5;
        dump_en = 1'b1;
        ra0 = raddrq.size();
        tx0 = txq.size();
        act = 0;
        @(negedge clk);
        dump_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            act = act | re | trmt | busy;
            @(negedge clk);
        end
        chk("nocap.activity", act, 0);
        chk("nocap.reads", raddrq.size() - ra0, 0);
        chk("nocap.bytes", txq.size() - tx0, 0);

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        wp = $urandom_range(0, ENTRIES - 1);
        start_dump(wp);
        wait_done("noise", 1);
        check_dump("noise", wp);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
            wp = (r == 0) ? $urandom_range(ENTRIES, 511)
                          : $urandom_range(0, ENTRIES - 1);
            start_dump(wp);
            wait_done("rand", 0);
            check_dump("rand", wp);
        end

        wp = $urandom_range(0, ENTRIES - 1);
        start_dump(wp);
        got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            if (txq.size() - tx0 >= 10) got = 1;
        end
        chk("rst.reach10", got, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.outs", {trmt, re, busy, dump_done}, 0);
        chk("rst.tx_data", tx_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst.no_done", done_cnt - dn0, 0);
        start_dump(wp);
        wait_done("rst2", 0);
        check_dump("rst2", wp);

`ifdef DUMP_CHKSUM_EN
        for (int i = 0; i < 512; i++) mem[i] = 8'h01;
        wp = $urandom_range(0, ENTRIES - 1);
        start_dump(wp);
        wait_done("ones", 0);
        check_dump("ones", wp);
        if (txq.size() > tx0 + ENTRIES)
            chk("ones.byte385", txq[tx0 + ENTRIES], 8'h80);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
